// File: rtl/punc_fetch_pkg.sv
// Shared types and constants for the PUNC LC-3 instruction fetch stage.
package punc_fetch_pkg;

    typedef enum logic {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

    localparam logic [3:0] OPC_HALT        = 4'hF;
    localparam int         FETCH_BUF_DEPTH = 2;
    localparam int         ENTRY_AW        = 16;
    localparam int         ENTRY_DW        = 16;

    typedef struct packed {
        logic [ENTRY_AW-1:0] pc;
        logic [ENTRY_DW-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_halt(input logic [15:0] word);
        return word[15:12] == OPC_HALT;
    endfunction

endpackage

// File: rtl/punc_fetch_buf.sv
// Two-entry FIFO between fetch and decode; flush wins over push and pop.
module punc_fetch_buf
    import punc_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    fetch_entry_t slot [FETCH_BUF_DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop && !empty;
    // a push into a full buffer is only legal when the head leaves this cycle
    assign do_push = push && (!full || do_pop);
    assign full    = (count == 2'(FETCH_BUF_DEPTH));
    assign empty   = (count == 2'd0);
    assign head    = slot[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot[0] <= '0;
            slot[1] <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count   <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                slot[wr_ptr] <= push_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/punc_fetch.sv
// PUNC LC-3 fetch stage: PC, HALT/redirect control, 2-entry output buffer.
// Define PUNC_FETCH_STALL_CNT_EN to build the saturating backpressure counter.
module punc_fetch
    import punc_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    output logic                  halted,
    output logic [15:0]           stall_count
);

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] pc;
    fetch_entry_t          head;
    fetch_entry_t          push_data;
    logic                  full;
    logic                  empty;
    logic                  pop;
    logic                  fetch;

    assign pop       = instr_valid && instr_ready;
    assign fetch     = (state == ST_FETCH) && (!full || pop) && !redirect_valid;
    assign push_data = '{pc: ENTRY_AW'(pc), instr: ENTRY_DW'(mem_data)};

    assign mem_addr    = pc;
    assign instr_valid = !empty;
    assign instr       = DATA_WIDTH'(head.instr);
    assign instr_pc    = ADDR_WIDTH'(head.pc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_FETCH;
            pc     <= RESET_PC;
            halted <= 1'b0;
        end else if (redirect_valid) begin
            state  <= ST_FETCH;
            pc     <= redirect_pc;
            halted <= 1'b0;
        end else if (fetch) begin
            // HALT is enqueued like any word, but the PC parks on it
            if (is_halt(16'(mem_data))) begin
                state  <= ST_HALTED;
                halted <= 1'b1;
            end else begin
                pc <= pc + ADDR_WIDTH'(1);
            end
        end
    end

    punc_fetch_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (fetch),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

`ifdef PUNC_FETCH_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= 16'h0000;
        end else if (instr_valid && !instr_ready && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'h0001;
        end
    end
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: doc/punc_fetch.md
# punc_fetch

Instruction fetch stage for the PUNC LC-3 datapath. Sits directly upstream of the decode/execute logic and downstream of the unified 2-read/1-write memory. Drives memory read port 0 with the program counter, captures the combinationally returned word, and presents `{pc, instruction}` pairs to decode through a 2-entry valid/ready buffer. Supports branch/jump redirect and stops fetching after a HALT.

## Interface
- `ADDR_WIDTH`, 16: PC and memory address width.
- `DATA_WIDTH`, 16: instruction width.
- `RESET_PC`, 16'h0000: PC loaded on reset.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous assert, active-low (0 = reset).
- `mem_addr`  out  ADDR_WIDTH: to memory `r_addr_0`; always equals current PC.
- `mem_data`  in  DATA_WIDTH: from memory `r_data_0`; valid in the same cycle as `mem_addr`.
- `redirect_valid`  in  1: one-cycle request to change the PC (taken branch, JMP).
- `redirect_pc`  in  ADDR_WIDTH: target; sampled when `redirect_valid`=1.
- `instr_valid`  out  1: buffer head is valid.
- `instr`  out  DATA_WIDTH: head instruction word.
- `instr_pc`  out  ADDR_WIDTH: address the head was fetched from.
- `instr_ready`  in  1: decode accepts head when `instr_valid && instr_ready`.
- `halted`  out  1: fetch stopped after enqueuing a HALT.
- `stall_count`  out  16: backpressure cycle counter (see Configuration).

## Operation
- State machine `FETCH`, `HALTED`. Reset state `FETCH`.
- Reset values: PC=`RESET_PC` (so `mem_addr`=`RESET_PC`), buffer empty, `instr_valid`=0, `instr`=0, `instr_pc`=0, `halted`=0, `stall_count`=0.
- `FETCH`: a fetch happens in any cycle where the buffer has space after this cycle's pop (count<2, or count==2 with a pop). On a fetch, `{PC, mem_data}` is pushed and PC increments by 1. PC wraps modulo 2^ADDR_WIDTH (FFFF -> 0000).
- HALT: a fetched word with `[15:12]`=4'hF is pushed normally. PC is not incremented, and state -> `HALTED`.
- `HALTED`: no fetches; buffered entries still drain; `halted`=1.
- Redirect, priority over everything:
  - buffer flushed, including an entry being popped or pushed this cycle;
  - PC <= `redirect_pc`;
  - state -> `FETCH` (resumes from `HALTED`);
  - no fetch that cycle.
  - A handshake in the redirect cycle still counts as accepted by decode.
- Simultaneous push and pop: count unchanged, FIFO order preserved.
- Buffer is first-in first-out. Head outputs change only on pop, flush or push-into-empty.
- Memory writes to already-buffered addresses are not tracked; stale words are delivered. Decode issues a redirect after stores if needed.

## Timing
- Reset deassert at edge E0: cycle after E0 shows `mem_addr`=`RESET_PC`. `instr_valid`=1 from the next cycle (1-cycle fetch latency).
- Redirect in cycle N: `mem_addr`=target in N+1, `instr_valid` with `instr_pc`=target in N+2. `instr_valid`=0 in N+1.
- Sustained throughput 1 instr/cycle with `instr_ready` held 1.
- `instr_ready` low: at most 2 entries held, then PC freezes. Fetching resumes in the same cycle as the freeing pop.
- Async reset mid-operation: all state and outputs take reset values immediately; no partial entry survives.

## Configuration
- `PUNC_FETCH_STALL_CNT_EN` defined:
  - `stall_count` increments in each cycle with `instr_valid && !instr_ready`;
  - saturates at 16'hFFFF;
  - cleared only by reset.
- Not defined: `stall_count` is tied to 0 and no counter logic is built.

## Structure
- Package `punc_fetch_pkg`:
  - fetch state enum;
  - `OPC_HALT` = 4'hF;
  - `FETCH_BUF_DEPTH` = 2;
  - entry struct `{pc, instr}`.
- Sub-module `punc_fetch_buf`: 2-entry FIFO with push, pop, flush, full/empty and count.

## Test plan
- Reset, memory[0..2]=1601,1842,1A02, `instr_ready`=1 -> valid on cycle 2 after release; outputs (0,1601),(1,1842),(2,1A02) on consecutive cycles.
- `instr_ready`=0 for 5 cycles after first valid -> PC frozen at 2, head (0,1601) stable. Then ready -> 0,1 delivered with no gap, and fetch of address 2 occurs in the first freeing cycle.
- Redirect to 0x0020 while the buffer holds 2 entries and a handshake is active -> `instr_valid`=0 next cycle, then (0x0020, mem[0x20]); pre-redirect entries never appear.
- mem[0x39]=F000 reached -> F000 delivered, `halted`=1, `mem_addr` stays 0x39. Redirect to 0 -> `halted`=0 and fetch resumes at 0.
- `RESET_PC`=16'hFFFE -> pcs FFFE, FFFF, 0000 delivered in order.
- With `PUNC_FETCH_STALL_CNT_EN`: 7 backpressure cycles -> `stall_count`=7, and assert `rst`=0 mid-stream -> all outputs 0 immediately. Without the macro, `stall_count` stays 0.
